mux_nto1_frame: RTL and testbench

Parametrised, registered N-to-1 multiplexer with a valid/ready output stream. One `start` pulse sends either a single selected channel (manual mode) or every channel in ascending order as one framed burst (scan mode). Each beat carries its channel index and a last-beat flag. The block sits between a bank of parallel sample sources and a serial consumer such as a UART or FIFO, and generalises the fixed 8:1 combinational selector in width, channel count and sequencing.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_next_ch.sv | 27 ++
 rtl/mux_nto1_frame.sv | 219 +++++++++++++++++++++
 tb/tb_mux_nto1_frame.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types for the framed N-to-1 multiplexer: FSM state encoding and
// the meaning of the `mode` input.
package mux_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Values of the `mode` input, sampled together with `start`.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_next_ch.sv
// Find-next-set-bit helper: returns the lowest channel index i with
// mask[i]=1 and i >= from. `none` flags that no such channel exists.
// `from` is one bit wider than a channel index so that "past the top
// channel" (from == N_CH) can be expressed.
module mux_next_ch #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W:0]   from,
  output logic [SEL_W-1:0] next_ch,
  output logic             none
);

  // Priority search, scanning downwards so the lowest qualifying index wins.
  always_comb begin
    next_ch = '0;
    none    = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        next_ch = SEL_W'(i);
        none    = 1'b0;
      end
    end
  end

endmodule : mux_next_ch

// File: rtl/mux_nto1_frame.sv
// Registered N-to-1 multiplexer with a valid/ready output stream.
// A `start` pulse in IDLE sends either one selected channel (manual mode)
// or all channels in ascending order as one framed burst (scan mode).
// Each beat carries its channel index, a last-beat flag and, for a bad
// manual select, an error flag with zeroed data.
//
// Optional feature: define MUX_CH_MASK_EN to add the `ch_mask` input; scan
// frames then visit only the enabled channels, and a scan start with an
// empty mask is ignored.
module mux_nto1_frame
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  input  logic                  stop,
`ifdef MUX_CH_MASK_EN
  input  logic [N_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy
);

  state_t state, state_nxt;

  // Unpacked view of the flat input bus, one entry per channel.
  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_split
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  logic accept;
  assign accept = out_valid && out_ready;

  // A manual select beyond the last channel still produces a beat, flagged.
  logic sel_bad;
  assign sel_bad = ({1'b0, sel} >= (SEL_W + 1)'(N_CH));

  // ---------------------------------------------------------------------
  // Scan sequencing. out_ch doubles as the scan channel counter: the next
  // channel is derived from the beat currently on the output. In IDLE the
  // search starts at channel 0 to find the first beat of a new frame.
  // scan_ch   : channel to load next
  // scan_last : that channel is the final one of the frame
  // scan_ok   : a scan frame has at least one channel to send
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0] scan_ch;
  logic             scan_last;
  logic             scan_ok;

`ifdef MUX_CH_MASK_EN
  logic [N_CH-1:0]  mask_q;
  logic [N_CH-1:0]  scan_mask;
  logic [SEL_W:0]   scan_from;
  logic [SEL_W:0]   last_from;
  logic             scan_none;
  logic [SEL_W-1:0] unused_after_ch;

  // The live mask input is only consulted at frame start; mid-frame the
  // copy captured with `start` is used so mask changes cannot skew a frame.
  assign scan_mask = (state == IDLE) ? ch_mask : mask_q;
  assign scan_from = (state == IDLE) ? '0 : ({1'b0, out_ch} + 1'b1);
  assign last_from = {1'b0, scan_ch} + 1'b1;

  mux_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next (
    .mask    (scan_mask),
    .from    (scan_from),
    .next_ch (scan_ch),
    .none    (scan_none)
  );

  // Second search from just above the chosen channel: if nothing is left,
  // the chosen channel is the highest enabled one and closes the frame.
  mux_next_ch #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_last (
    .mask    (scan_mask),
    .from    (last_from),
    .next_ch (unused_after_ch),
    .none    (scan_last)
  );

  assign scan_ok = !scan_none;

  // Capture the channel mask with an honoured start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking (<=)
    // assignments so every register samples pre-edge values.
    if (rst) begin
      mask_q <= '0;
    end else if ((state == IDLE) && start) begin
      mask_q <= ch_mask;
    end
  end
`else
  // Every channel is scanned: plain increment, wrap never used because the
  // frame ends on the last channel.
  assign scan_ch   = (state == IDLE) ? '0 : (out_ch + 1'b1);
  assign scan_last = (scan_ch == SEL_W'(N_CH - 1));
  assign scan_ok   = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Next-state and output-register load decode.
  // ---------------------------------------------------------------------
  logic             load;
  logic             valid_nxt;
  logic [WIDTH-1:0] load_data;
  logic [SEL_W-1:0] load_ch;
  logic             load_last;
  logic             load_err;

  // Decide the next state and whether (and with what) the beat register loads.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    valid_nxt = out_valid;
    load      = 1'b0;
    load_data = '0;
    load_ch   = '0;
    load_last = 1'b0;
    load_err  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (mode == MODE_MANUAL) begin
            state_nxt = MANUAL;
            valid_nxt = 1'b1;
            load      = 1'b1;
            load_ch   = sel;
            load_err  = sel_bad;
            load_data = sel_bad ? '0 : ch_data[sel];
            load_last = 1'b1;
          end else if (scan_ok) begin
            state_nxt = SCAN;
            valid_nxt = 1'b1;
            load      = 1'b1;
            load_ch   = scan_ch;
            load_data = ch_data[scan_ch];
            load_last = scan_last;
          end
        end
      end

      MANUAL: begin
        // The single beat leaves; `stop` has no meaning here.
        if (accept) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end

      SCAN: begin
        // An abort wins over advancing; a beat accepted on the same edge is
        // still considered delivered by the consumer.
        if (stop || (accept && out_last)) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (accept) begin
          valid_nxt = 1'b1;
          load      = 1'b1;
          load_ch   = scan_ch;
          load_data = ch_data[scan_ch];
          load_last = scan_last;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State register and output beat register; the beat holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      if (load) begin
        out_data <= load_data;
        out_ch   <= load_ch;
        out_last <= load_last;
        out_err  <= load_err;
      end
    end
  end

  // Busy straight from the state register, so it is glitch-free and has no
  // dependence on out_ready.
  assign busy = (state != IDLE);

endmodule : mux_nto1_frame

// File: tb/tb_mux_nto1_frame.sv
// Self-checking bench for mux_nto1_frame (N_CH=8, WIDTH=8).
// A transaction-level reference model keeps the frame as a queue of
// channels still to send, computed from mode/sel/mask when start is
// honoured; every cycle all outputs are compared against it. Directed
// scenarios are followed by a randomized phase.
module tb_mux_nto1_frame;
  import mux_pkg::*;

  localparam int N_CH  = 8;
  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  start;
  logic                  stop;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_err;
  logic                  busy;
`ifdef MUX_CH_MASK_EN
  logic [N_CH-1:0]       ch_mask;
`endif

  mux_nto1_frame #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .mode      (mode),
    .sel       (sel),
    .start     (start),
    .stop      (stop),
`ifdef MUX_CH_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit         m_busy, m_manual, m_valid, m_last, m_err;
  logic [7:0] m_data;
  int         m_ch;
  int         q[$];          // channels of the current frame not yet accepted
  int         delivered[$];  // channels the consumer accepted

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] chan(input int c);
    return in_data[c*WIDTH +: WIDTH];
  endfunction

  function automatic bit enabled(input int c);
`ifdef MUX_CH_MASK_EN
    return ch_mask[c];
`else
    return (c >= 0);
`endif
  endfunction

  // Present the head of the frame queue as the current beat.
  task automatic model_load();
    m_valid = 1'b1;
    m_ch    = q[0];
    m_err   = (m_ch >= N_CH);
    m_data  = m_err ? 8'h00 : chan(m_ch);
    m_last  = (q.size() == 1);
  endtask

  // One clock edge: advance the model with the inputs sampled at that edge,
  // then compare all outputs 1 time unit later.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = m_valid && out_ready;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_last = 0; m_err = 0; m_data = '0; m_ch = 0;
      q.delete();
    end else if (!m_busy) begin
      if (start) begin
        q.delete();
        if (mode == MODE_MANUAL) begin
          m_manual = 1;
          q.push_back(int'(sel));
        end else begin
          m_manual = 0;
          for (int c = 0; c < N_CH; c++) if (enabled(c)) q.push_back(c);
        end
        if (q.size() > 0) begin
          m_busy = 1;
          model_load();
        end
      end
    end else if (!m_manual && stop) begin
      if (acc) delivered.push_back(m_ch);
      m_busy = 0; m_valid = 0;
      q.delete();
    end else if (acc) begin
      delivered.push_back(m_ch);
      void'(q.pop_front());
      if (q.size() == 0) begin
        m_busy = 0; m_valid = 0;
      end else begin
        model_load();
      end
    end
    #1;
    check("valid", out_valid, m_valid);
    check("busy",  busy,      m_busy);
    check("data",  out_data,  m_data);
    check("ch",    out_ch,    m_ch);
    check("last",  out_last,  m_last);
    check("err",   out_err,   m_err);
  endtask

  task automatic set_pattern();
    for (int i = 0; i < N_CH; i++) in_data[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
  endtask

  task automatic run_to_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) tick();
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic pulse_start(input logic md, input logic [SEL_W-1:0] s);
    mode = md; sel = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
`ifdef MUX_CH_MASK_EN
    ch_mask = '1;
`endif
    m_busy = 0; m_manual = 0; m_valid = 0; m_last = 0; m_err = 0; m_data = '0; m_ch = 0;
    set_pattern();
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_data",  out_data,  8'h00);
    check("rst_valid", out_valid, 1'b0);

    // Reset in the middle of a scan frame, then a clean frame.
    out_ready = 1'b1;
    pulse_start(MODE_SCAN, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",  busy,      1'b0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ch",    out_ch,    3'd0);
    check("midrst_data",  out_data,  8'h00);
    delivered.delete();
    pulse_start(MODE_SCAN, '0);
    run_to_idle(20);
    check("clean_beats", delivered.size(), 8);

    // Manual select of channel 5.
    delivered.delete();
    pulse_start(MODE_MANUAL, 3'd5);
    check("man_data", out_data, 8'h15);
    check("man_ch",   out_ch,   3'd5);
    check("man_last", out_last, 1'b1);
    tick();
    check("man_busy", busy, 1'b0);
    check("man_beats", delivered.size(), 1);

    // Full scan with the consumer always ready.
    delivered.delete();
    pulse_start(MODE_SCAN, '0);
    for (int k = 0; k < N_CH; k++) begin
      check($sformatf("scan_d%0d", k), out_data, 32'(8'h10 + k));
      check($sformatf("scan_l%0d", k), out_last, (k == N_CH - 1));
      tick();
    end
    check("scan_busy", busy, 1'b0);
    check("scan_beats", delivered.size(), 8);

    // Stall on channel 2 while the inputs change underneath.
    delivered.delete();
    pulse_start(MODE_SCAN, '0);
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data = {$urandom(), $urandom()};
      tick();
      check("stall_data", out_data, 8'h12);
      check("stall_ch",   out_ch,   3'd2);
    end
    set_pattern();
    out_ready = 1'b1;
    tick();
    check("post_stall", out_data, 8'h13);
    run_to_idle(20);
    check("stall_beats", delivered.size(), 8);

    // Stop during the channel-4 beat; starts inside the frame are ignored.
    delivered.delete();
    pulse_start(MODE_SCAN, '0);
    pulse_start(MODE_MANUAL, 3'd1);
    for (int k = 0; k < 20 && !(out_valid && out_ch == 3'd4); k++) tick();
    check("stop_reach", out_ch, 3'd4);
    stop = 1'b1;
    mode = MODE_MANUAL; sel = 3'd6; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stop_valid", out_valid, 1'b0);
    check("stop_busy",  busy,      1'b0);
    check("stop_beats", delivered.size(), 5);
    check("stop_lastch", delivered[$], 4);
    tick();

`ifdef MUX_CH_MASK_EN
    // Sparse mask, then an empty mask.
    delivered.delete();
    ch_mask = 8'b1010_0100;
    pulse_start(MODE_SCAN, '0);
    ch_mask = '1;
    run_to_idle(20);
    check("mask_beats", delivered.size(), 3);
    check("mask_ch0", delivered[0], 2);
    check("mask_ch1", delivered[1], 5);
    check("mask_ch2", delivered[2], 7);
    ch_mask = '0;
    pulse_start(MODE_SCAN, '0);
    check("mask0_busy", busy, 1'b0);
    ch_mask = '1;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 3) == 0);
      mode      = 1'($urandom());
      sel       = SEL_W'($urandom());
      stop      = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom(), $urandom()};
`ifdef MUX_CH_MASK_EN
      ch_mask   = N_CH'($urandom());
`endif
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    run_to_idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mux_nto1_frame
